// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//  - RV32 funct3 encodings for loads and stores
//  - FSM state encoding
//  - request classification helpers (misalignment, illegal funct3)
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

  // Halfwords need an even address, words need a word-aligned address.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] lane);
    case (funct3)
      F3_H, F3_HU: return lane[0];
      F3_W:        return lane != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Unsigned widths only exist for loads; 011/110/111 are never legal.
  function automatic logic is_illegal_f3(input logic [2:0] funct3,
                                         input logic       store);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return store;
      default:          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the load/store unit (purely combinational).
//  load_word   in   32  RAM word the load is extracted from
//  merge_word  in   32  previously read RAM word that a sub-word store patches
//  wdata       in   32  store data (low byte/half used for SB/SH)
//  lane        in   2   byte offset within the word
//  funct3      in   3   access width / signedness
//  load_data   out  32  extracted and sign/zero-extended load value
//  merged      out  32  word to write back (full wdata for SW)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] load_word,
  input  logic [31:0] merge_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statements can leave a latch behind.
    byte_sel  = load_word[{lane, 3'b000} +: 8];
    half_sel  = lane[1] ? load_word[31:16] : load_word[15:0];
    load_data = load_word;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = load_word;
    endcase
  end

  always_comb begin
    merged = merge_word;
    case (funct3)
      F3_B: merged[{lane, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      F3_W:    merged = wdata;
      default: merged = merge_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the RV32IM execute stage and a word-wide data RAM
// (combinational read, synchronous word write). Sub-word stores are done as
// read-modify-write; flagged requests never touch the RAM.
//  clk, rst                      clock, synchronous active-high reset
//  req_valid/req_ready           request handshake (ready only in IDLE)
//  req_store/req_funct3/req_addr/req_wdata   request fields, latched on accept
//  resp_valid/resp_rdata/resp_err            one-cycle response
//  mem_addr/mem_we/mem_din/mem_dout          RAM port (word-aligned address)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [31:0]       mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_WORDS * 4);

  lsu_state_e        state_q;
  logic              store_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;

  logic              req_err;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  assign req_err = is_illegal_f3(req_funct3, req_store)
                 | is_misaligned(req_funct3, req_addr[1:0])
                 | (req_addr >= ADDR_LIMIT);

  // Loads extract straight from the RAM output during READ so the response
  // register is loaded on the same edge that leaves READ; stores merge into
  // the word captured in READ.
  lsu_align u_align (
    .load_word  (mem_dout),
    .merge_word (word_q),
    .wdata      (wdata_q),
    .lane       (addr_q[1:0]),
    .funct3     (funct3_q),
    .load_data  (load_data),
    .merged     (merged)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout, so every register here sees
    // the pre-edge value of every other one regardless of statement order.
    if (rst) begin
      state_q      <= ST_IDLE;
      store_q      <= 1'b0;
      funct3_q     <= F3_W;
      addr_q       <= '0;
      wdata_q      <= '0;
      word_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            store_q  <= req_store;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (req_err) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= '0;
              resp_err_q   <= 1'b1;
            end else if (req_store && req_funct3 == F3_W) begin
              state_q <= ST_WRITE;
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          word_q <= mem_dout;
          if (store_q) begin
            state_q <= ST_WRITE;
          end else begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_data;
            resp_err_q   <= 1'b0;
          end
        end
        ST_WRITE: begin
          state_q      <= ST_RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // Gated by rst directly so a reset landing in WRITE cannot corrupt RAM.
  assign mem_we   = (state_q == ST_WRITE) && !rst;
  assign mem_addr = 32'({addr_q[ADDR_W-1:2], 2'b00});
  assign mem_din  = merged;

endmodule
